// File: rtl/audio_seq_pkg.sv
// Shared types and constants for the audio path sequencer.
// Contents: sequencer state encoding, gain/data widths, status bit positions,
// and saturating gain-ramp helpers.
package audio_seq_pkg;

  localparam int unsigned DATA_W     = 24;
  localparam int unsigned GAIN_W     = 9;
  localparam int unsigned GAIN_UNITY = 256;
  localparam int unsigned STATE_W    = 3;

  // seq_status layout: [2:0] state, [3] sticky lost, [4] switch pending
  localparam int unsigned ST_LOST_BIT = 3;
  localparam int unsigned ST_PEND_BIT = 4;

  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(GAIN_UNITY);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_LOCK      = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_RUN       = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_SWITCH    = 3'd5
  } seq_state_e;

  // Gain + step, clamped at unity.
  function automatic logic [GAIN_W-1:0] gain_up(input logic [GAIN_W-1:0] g,
                                                input logic [GAIN_W-1:0] step);
    logic [GAIN_W:0] sum;
    sum = {1'b0, g} + {1'b0, step};
    return (sum >= {1'b0, GAIN_ONE}) ? GAIN_ONE : sum[GAIN_W-1:0];
  endfunction

  // Gain - step, clamped at zero.
  function automatic logic [GAIN_W-1:0] gain_dn(input logic [GAIN_W-1:0] g,
                                                input logic [GAIN_W-1:0] step);
    return (g > step) ? (g - step) : '0;
  endfunction

endpackage

// File: rtl/audio_path_sequencer_if.sv
// Control, status and stereo sample bus of the audio path sequencer.
// master: CPU / audio mux / I2S side (drives requests and samples in).
// slave : the sequencer (drives run, mux select, gained samples, status).
interface audio_path_sequencer_if;
  import audio_seq_pkg::*;

  logic              enable_req;
  logic [1:0]        mux_sel_req;
  logic              status_clr;
  logic              src_valid;
  logic              l_data_en;
  logic              r_data_en;
  logic [DATA_W-1:0] l_data_in;
  logic [DATA_W-1:0] r_data_in;
  logic              audio_run;
  logic [1:0]        mux_sel;
  logic              l_data_valid;
  logic              r_data_valid;
  logic [DATA_W-1:0] l_data_out;
  logic [DATA_W-1:0] r_data_out;
  logic [GAIN_W-1:0] gain;
  logic [7:0]        seq_status;

  modport master (
    output enable_req, mux_sel_req, status_clr, src_valid,
           l_data_en, r_data_en, l_data_in, r_data_in,
    input  audio_run, mux_sel, l_data_valid, r_data_valid,
           l_data_out, r_data_out, gain, seq_status
  );

  modport slave (
    input  enable_req, mux_sel_req, status_clr, src_valid,
           l_data_en, r_data_en, l_data_in, r_data_in,
    output audio_run, mux_sel, l_data_valid, r_data_valid,
           l_data_out, r_data_out, gain, seq_status
  );
endinterface

// File: rtl/audio_gain_stage.sv
// One-channel gain stage: registered (sample * gain) >>> 8 with a one-clock
// valid delay. Output holds its last value between strobes.
// Ports: clk, reset_n, data_en/data_in (sample strobe and signed sample),
// gain (unsigned, 256 = unity), data_valid/data_out (registered result).
module audio_gain_stage
  import audio_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [GAIN_W-1:0] gain,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out
);

  // 24-bit signed x 9-bit unsigned (<= 256) always fits in 32 signed bits.
  localparam int unsigned PROD_W = DATA_W + GAIN_W - 1;

  logic signed [PROD_W-1:0] prod;
  logic                     valid_d, valid_q;
  logic [DATA_W-1:0]        data_d, data_q;

  always_comb begin
    prod    = PROD_W'($signed(data_in)) * $signed(PROD_W'(gain));
    valid_d = data_en;
    data_d  = data_en ? DATA_W'(prod >>> 8) : data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign data_valid = valid_q;
  assign data_out   = data_q;

endmodule

// File: rtl/audio_path_sequencer.sv
// Click-free start/stop and source-switch controller for the audio datapath.
// Gates the pipeline run signal, owns the mux select, ramps a per-sample gain
// on enable/disable/source change, and mutes when I2S input samples stop.
// Ports: clk, reset_n (async, active-low), bus (slave side of
// audio_path_sequencer_if: requests, sample strobes/data in, run, mux_sel,
// gained samples out, gain and seq_status).
module audio_path_sequencer
  import audio_seq_pkg::*;
#(
  parameter int unsigned LOCK_SAMPLES  = 16,
  parameter int unsigned RAMP_STEP     = 4,
  parameter int unsigned FLUSH_SAMPLES = 8,
  parameter int unsigned WDOG_CYCLES   = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  audio_path_sequencer_if.slave  bus
);

  localparam int unsigned LOCK_W  = $clog2(LOCK_SAMPLES + 1);
  localparam int unsigned FLUSH_W = $clog2(FLUSH_SAMPLES + 1);
  localparam int unsigned WDOG_W  = $clog2(WDOG_CYCLES + 1);

  localparam logic [GAIN_W-1:0]  STEP_G     = GAIN_W'(RAMP_STEP);
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_SAMPLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_SAMPLES - 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);

  seq_state_e         state_d, state_q;
  logic               audio_run_d, audio_run_q;
  logic [1:0]         mux_sel_d, mux_sel_q;
  logic [GAIN_W-1:0]  gain_d, gain_q;
  logic [LOCK_W-1:0]  lock_cnt_d, lock_cnt_q;
  logic [FLUSH_W-1:0] flush_cnt_d, flush_cnt_q;
  logic [WDOG_W-1:0]  wdog_cnt_d, wdog_cnt_q;
  logic               lost_d, lost_q;
  logic               pend_d, pend_q;
  logic               tick, mux_chg, wdog_active, wdog_fire;
  logic [7:0]         status;

  // Next-state, gain ramp, counters and watchdog.
  always_comb begin
    state_d     = state_q;
    mux_sel_d   = mux_sel_q;
    gain_d      = gain_q;
    lock_cnt_d  = (state_q == S_LOCK) ? lock_cnt_q : '0;
    flush_cnt_d = flush_cnt_q;
    pend_d      = pend_q;
    lost_d      = lost_q;
    tick        = bus.l_data_en;
    mux_chg     = (bus.mux_sel_req != mux_sel_q);
    wdog_active = (state_q == S_RAMP_UP) || (state_q == S_RUN) ||
                  (state_q == S_RAMP_DOWN) || (state_q == S_SWITCH);
    wdog_cnt_d  = (wdog_active && !bus.src_valid) ? wdog_cnt_q + 1'b1 : '0;
    wdog_fire   = wdog_active && !bus.src_valid && (wdog_cnt_q == WDOG_LAST);

    case (state_q)
      S_IDLE: begin
        mux_sel_d = bus.mux_sel_req;
        gain_d    = '0;
        if (bus.enable_req) state_d = S_LOCK;
      end
      S_LOCK: begin
        mux_sel_d = bus.mux_sel_req;
        gain_d    = '0;
        if (!bus.enable_req) begin
          state_d = S_IDLE;
        end else if (bus.src_valid) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
          if (lock_cnt_q == LOCK_LAST) state_d = S_RAMP_UP;
        end
      end
      S_RAMP_UP, S_RUN: begin
        if (state_q == S_RUN) gain_d = GAIN_ONE;
        if (!bus.enable_req) begin
          state_d = S_RAMP_DOWN;
        end else if (mux_chg) begin
          pend_d  = 1'b1;
          state_d = S_RAMP_DOWN;
        end else if (state_q == S_RAMP_UP && tick) begin
          gain_d = gain_up(gain_q, STEP_G);
          if (gain_d == GAIN_ONE) state_d = S_RUN;
        end
      end
      S_RAMP_DOWN: begin
        if (bus.enable_req && !pend_q) begin
          state_d = S_RAMP_UP;
        end else begin
          gain_d = tick ? gain_dn(gain_q, STEP_G) : gain_q;
          if (gain_d == '0) begin
            pend_d = 1'b0;
            if (!bus.enable_req) begin
              state_d = S_IDLE;
            end else begin
              // Source is swapped only once the output is fully muted.
              state_d     = S_SWITCH;
              mux_sel_d   = bus.mux_sel_req;
              flush_cnt_d = '0;
            end
          end
        end
      end
      S_SWITCH: begin
        gain_d = '0;
        if (!bus.enable_req) begin
          state_d = S_IDLE;
        end else if (mux_chg) begin
          mux_sel_d   = bus.mux_sel_req;
          flush_cnt_d = '0;
        end else if (tick) begin
          if (flush_cnt_q == FLUSH_LAST) begin
            flush_cnt_d = '0;
            state_d     = S_RAMP_UP;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loss of input overrides every other transition.
    if (wdog_fire) begin
      state_d     = bus.enable_req ? S_LOCK : S_IDLE;
      gain_d      = '0;
      mux_sel_d   = mux_sel_q;
      pend_d      = 1'b0;
      lock_cnt_d  = '0;
      flush_cnt_d = '0;
    end

    if (wdog_fire)           lost_d = 1'b1;
    else if (bus.status_clr) lost_d = 1'b0;

    audio_run_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      audio_run_q <= 1'b0;
      mux_sel_q   <= '0;
      gain_q      <= '0;
      lock_cnt_q  <= '0;
      flush_cnt_q <= '0;
      wdog_cnt_q  <= '0;
      lost_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      audio_run_q <= audio_run_d;
      mux_sel_q   <= mux_sel_d;
      gain_q      <= gain_d;
      lock_cnt_q  <= lock_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wdog_cnt_q  <= wdog_cnt_d;
      lost_q      <= lost_d;
      pend_q      <= pend_d;
    end
  end

  always_comb begin
    status                   = '0;
    status[STATE_W-1:0]      = state_q;
    status[ST_LOST_BIT]      = lost_q;
    status[ST_PEND_BIT]      = pend_q;
  end

  assign bus.audio_run  = audio_run_q;
  assign bus.mux_sel    = mux_sel_q;
  assign bus.gain       = gain_q;
  assign bus.seq_status = status;

  // Samples take the gain that is in effect on their own strobe edge.
  audio_gain_stage u_gain_l (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_en    (bus.l_data_en),
    .data_in    (bus.l_data_in),
    .gain       (gain_d),
    .data_valid (bus.l_data_valid),
    .data_out   (bus.l_data_out)
  );

  audio_gain_stage u_gain_r (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_en    (bus.r_data_en),
    .data_in    (bus.r_data_in),
    .gain       (gain_d),
    .data_valid (bus.r_data_valid),
    .data_out   (bus.r_data_out)
  );

endmodule

// File: tb/tb_audio_path_sequencer.sv
// Directed self-checking bench for audio_path_sequencer: startup, shutdown,
// source switch, watchdog, ramp abort and asynchronous reset mid-ramp.
module tb_audio_path_sequencer;
  import audio_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   src_auto = 1'b0;
  logic [47:0] sb_q[$];
  logic [23:0] dl = 24'h100000;
  logic [23:0] dr = 24'hF00000;

  audio_path_sequencer_if bus();

  audio_path_sequencer #(
    .LOCK_SAMPLES (4),
    .RAMP_STEP    (64),
    .FLUSH_SAMPLES(2),
    .WDOG_CYCLES  (200)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] scale(input logic [23:0] x, input int g);
    logic signed [33:0] p;
    p = $signed({{10{x[23]}}, x}) * $signed(34'(g));
    return p[31:8];
  endfunction

  function automatic logic [31:0] st();
    return 32'(bus.seq_status[2:0]);
  endfunction

  // One clock; checks output strobes and pops the scoreboard on a strobe.
  task automatic step(input bit tk, input bit sv);
    logic [47:0] e;
    bus.l_data_en = tk;
    bus.r_data_en = tk;
    bus.src_valid = sv | (src_auto & (cyc % 4 == 0));
    @(posedge clk); #1;
    cyc++;
    bus.l_data_en = 1'b0;
    bus.r_data_en = 1'b0;
    bus.src_valid = 1'b0;
    chk("l_valid", 32'(bus.l_data_valid), 32'(tk));
    chk("r_valid", 32'(bus.r_data_valid), 32'(tk));
    if (tk && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("l_out", 32'(bus.l_data_out), 32'(e[47:24]));
      chk("r_out", 32'(bus.r_data_out), 32'(e[23:0]));
    end
  endtask

  task automatic tick(input logic [23:0] l, input logic [23:0] r, input int g);
    bus.l_data_in = l;
    bus.r_data_in = r;
    sb_q.push_back({scale(l, g), scale(r, g)});
    step(1'b1, 1'b0);
    chk("gain", 32'(bus.gain), 32'(g));
  endtask

  task automatic ramp(input int from, input int to);
    int g;
    g = from;
    while (g != to) begin
      g = (to > from) ? g + 64 : g - 64;
      step(1'b0, 1'b0);
      tick(dl, dr, g);
    end
  endtask

  task automatic wait_state(input logic [31:0] s, input int budget);
    int n;
    n = 0;
    while (st() != s && n < budget) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("wait_state", st(), s);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, st(), 32'(S_IDLE));
    chk({tag, "_run"},   32'(bus.audio_run), 0);
    chk({tag, "_mux"},   32'(bus.mux_sel), 0);
    chk({tag, "_gain"},  32'(bus.gain), 0);
    chk({tag, "_lval"},  32'(bus.l_data_valid), 0);
    chk({tag, "_rval"},  32'(bus.r_data_valid), 0);
    chk({tag, "_lout"},  32'(bus.l_data_out), 0);
    chk({tag, "_rout"},  32'(bus.r_data_out), 0);
    chk({tag, "_stat"},  32'(bus.seq_status), 0);
  endtask

  initial begin
    int n;
    reset_n         = 1'b0;
    bus.enable_req  = 1'b0;
    bus.mux_sel_req = 2'd0;
    bus.status_clr  = 1'b0;
    bus.src_valid   = 1'b0;
    bus.l_data_en   = 1'b0;
    bus.r_data_en   = 1'b0;
    bus.l_data_in   = '0;
    bus.r_data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    reset_n = 1'b1;
    step(1'b0, 1'b0);

    // IDLE: mux select follows the request
    bus.mux_sel_req = 2'd1;
    step(1'b0, 1'b0);
    chk("idle_mux", 32'(bus.mux_sel), 1);
    chk("idle_run", 32'(bus.audio_run), 0);
    bus.mux_sel_req = 2'd0;
    step(1'b0, 1'b0);

    // Startup: lock on 4 src_valid, then ramp 64..256
    bus.enable_req = 1'b1;
    step(1'b0, 1'b0);
    chk("lock_state", st(), 32'(S_LOCK));
    chk("lock_run", 32'(bus.audio_run), 1);
    chk("lock_gain", 32'(bus.gain), 0);
    repeat (3) step(1'b0, 1'b1);
    chk("lock_hold", st(), 32'(S_LOCK));
    step(1'b0, 1'b1);
    chk("lock_done", st(), 32'(S_RAMP_UP));
    src_auto = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0);
      tick(24'h100000, 24'hF00000, 64 * i);
      if (i == 1) chk("up_first_out", 32'(bus.l_data_out), 32'h040000);
      chk("up_state", st(), (i == 4) ? 32'(S_RUN) : 32'(S_RAMP_UP));
    end
    chk("unity_out", 32'(bus.l_data_out), 32'h100000);

    // Shutdown: ramp 192..0 then IDLE
    bus.enable_req = 1'b0;
    step(1'b0, 1'b0);
    chk("dn_state", st(), 32'(S_RAMP_DOWN));
    ramp(256, 0);
    chk("off_state", st(), 32'(S_IDLE));
    chk("off_run", 32'(bus.audio_run), 0);
    chk("off_out", 32'(bus.l_data_out), 0);

    // Source switch 0 -> 2
    bus.enable_req = 1'b1;
    wait_state(32'(S_RAMP_UP), 40);
    ramp(0, 256);
    chk("sw_run", st(), 32'(S_RUN));
    bus.mux_sel_req = 2'd2;
    step(1'b0, 1'b0);
    chk("sw_dn_state", st(), 32'(S_RAMP_DOWN));
    chk("sw_pend", 32'(bus.seq_status[4]), 1);
    for (int g = 192; g > 0; g -= 64) begin
      step(1'b0, 1'b0);
      tick(dl, dr, g);
      chk("sw_pend_dn", 32'(bus.seq_status[4]), 1);
      chk("sw_mux_hold", 32'(bus.mux_sel), 0);
    end
    step(1'b0, 1'b0);
    tick(dl, dr, 0);
    chk("sw_state", st(), 32'(S_SWITCH));
    chk("sw_mux", 32'(bus.mux_sel), 2);
    chk("sw_pend_clr", 32'(bus.seq_status[4]), 0);
    step(1'b0, 1'b0);
    tick(dl, dr, 0);
    chk("sw_flush1", st(), 32'(S_SWITCH));
    step(1'b0, 1'b0);
    tick(dl, dr, 0);
    chk("sw_flush2", st(), 32'(S_RAMP_UP));
    ramp(0, 256);
    chk("sw_done", st(), 32'(S_RUN));
    chk("sw_mux_final", 32'(bus.mux_sel), 2);

    // Abort ramp down at 128 and resume
    bus.enable_req = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    tick(dl, dr, 192);
    step(1'b0, 1'b0);
    tick(24'h800000, 24'h7FFFFF, 128);
    chk("neg_out", 32'(bus.l_data_out), 32'hC00000);
    bus.enable_req = 1'b1;
    step(1'b0, 1'b0);
    chk("abort_state", st(), 32'(S_RAMP_UP));
    chk("abort_gain", 32'(bus.gain), 128);
    ramp(128, 256);
    chk("abort_run", st(), 32'(S_RUN));

    // Watchdog: 200 clocks without src_valid
    src_auto = 1'b0;
    step(1'b0, 1'b1);
    n = 0;
    while (st() != 32'(S_LOCK) && n < 300) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("wdog_cycles", 32'(n), 200);
    chk("wdog_gain", 32'(bus.gain), 0);
    chk("wdog_lost", 32'(bus.seq_status[3]), 1);
    chk("wdog_run", 32'(bus.audio_run), 1);
    bus.status_clr = 1'b1;
    step(1'b0, 1'b0);
    bus.status_clr = 1'b0;
    chk("lost_clr", 32'(bus.seq_status[3]), 0);
    repeat (3) step(1'b0, 1'b1);
    chk("relock_hold", st(), 32'(S_LOCK));
    step(1'b0, 1'b1);
    chk("relock_done", st(), 32'(S_RAMP_UP));

    // Asynchronous reset in the middle of a ramp
    src_auto = 1'b1;
    step(1'b0, 1'b0);
    tick(dl, dr, 64);
    chk("pre_rst_state", st(), 32'(S_RAMP_UP));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    src_auto = 1'b0;
    bus.enable_req = 1'b0;
    step(1'b0, 1'b0);
    chk("post_rst_state", st(), 32'(S_IDLE));
    chk("sb_empty", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_path_sequencer.md
Name: audio_path_sequencer

Overview:
Click-free start/stop and source-switch controller for the audio datapath. Sits between the audio output mux and the PCM-to-I2S converter / VU meter driver. It gates the pipeline run signal, owns the mux select, and applies a per-sample gain ramp so enable, disable and source changes never produce steps at the DAC. It also watches the I2S front end and mutes immediately when input samples stop arriving.

Parameters:
LOCK_SAMPLES, 16, src_valid strobes required after enable before unmuting
RAMP_STEP, 4, gain increment/decrement per sample tick (gain range 0..256)
FLUSH_SAMPLES, 8, sample ticks held muted after a mux select change
WDOG_CYCLES, 4096, clk cycles without src_valid before declaring loss of input

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable_req  in  1  CPU enable (audio_control[0])
mux_sel_req  in  2  CPU source select (audio_control[2:1])
status_clr  in  1  strobe; clears the sticky lost bit
src_valid  in  1  I2S-to-PCM dout_valid strobe (watchdog and lock)
l_data_en  in  1  left sample strobe from the audio mux; also the ramp tick
r_data_en  in  1  right sample strobe from the audio mux
l_data_in  in  24  signed left sample
r_data_in  in  24  signed right sample
audio_run  out  1  run/audio_en to the upstream pipeline
mux_sel  out  2  applied mux select
l_data_valid  out  1  left output strobe
r_data_valid  out  1  right output strobe
l_data_out  out  24  gained left sample
r_data_out  out  24  gained right sample
gain  out  9  current gain, unsigned, 256 = unity
seq_status  out  8  [2:0] state, [3] lost (sticky), [4] switch pending, [7:5] 0

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE, audio_run 0, mux_sel 0, gain 0, all valids 0, all data 0, status 0, counters 0.
- States and encodings: IDLE=0, LOCK=1, RAMP_UP=2, RUN=3, RAMP_DOWN=4, SWITCH=5.
- IDLE: audio_run=0, gain=0, mux_sel tracks mux_sel_req every cycle. enable_req=1 -> LOCK with the lock counter cleared.
- LOCK: audio_run=1, gain=0, mux_sel tracks mux_sel_req. Each src_valid increments the lock counter; count==LOCK_SAMPLES -> RAMP_UP. enable_req=0 -> IDLE next cycle.
- RAMP_UP: on each l_data_en, gain = min(gain+RAMP_STEP, 256). gain==256 -> RUN. enable_req=0 -> RAMP_DOWN. mux_sel_req!=mux_sel -> set pending, go to RAMP_DOWN.
- RUN: gain=256. enable_req=0 -> RAMP_DOWN. mux_sel_req!=mux_sel -> set pending, go to RAMP_DOWN.
- RAMP_DOWN: on each l_data_en, gain = max(gain-RAMP_STEP, 0).
  - enable_req back to 1 with no pending switch -> RAMP_UP from the current gain.
  - At gain==0: if !enable_req -> IDLE (pending cleared); else if pending -> SWITCH; else -> RAMP_UP.
- SWITCH: on entry, mux_sel <= mux_sel_req and pending is cleared. Count FLUSH_SAMPLES l_data_en ticks with gain=0, then -> RAMP_UP. enable_req=0 -> IDLE. Further mux_sel_req changes during SWITCH are applied and restart the flush count.
- Watchdog: counts clk since the last src_valid and is active in RAMP_UP, RUN, RAMP_DOWN and SWITCH. When it reaches WDOG_CYCLES: gain forced to 0 the same cycle, lost bit set, next state LOCK (or IDLE if !enable_req). status_clr has lower priority than a same-cycle set.
- Simultaneous events:
  - Watchdog has priority over all transitions.
  - enable_req=0 has priority over a mux change.
  - The gain update and the state transition caused by the same tick both take effect on that tick.
- Datapath:
  - l_data_out = (l_data_in * gain) >>> 8 (signed 24 x unsigned 9 -> 33 bits, bits [31:8]); same for right.
  - gain 256 is exact passthrough; no saturation is needed.
  - Latency is 1 clk: l_data_valid is l_data_en delayed one clock, and likewise for right.
  - Left and right use the gain value sampled at their own strobe.
  - Outputs hold their last value between strobes.
- Reset mid-ramp returns everything to reset values immediately; there is no ramp on reset.

Decomposition:
- Package audio_seq_pkg holds:
  - state encodings (3-bit)
  - GAIN_UNITY=256, GAIN_W=9
  - status bit indices
- Sub-module audio_gain_stage: one instance per channel; registered multiply-shift plus valid delay. FSM, counters and watchdog stay in the top module.

Test Plan:
- Bench parameters: LOCK_SAMPLES=4, RAMP_STEP=64, FLUSH_SAMPLES=2, WDOG_CYCLES=200.
- Startup: enable_req=1, 4 src_valid pulses -> audio_run=1 in LOCK; after 4 l_data_en ticks gain steps 64,128,192,256, state RUN; input 0x100000 gives outputs 0x040000, 0x080000, 0x0C0000, 0x100000.
- Shutdown: in RUN drop enable_req -> gain 192,128,64,0 over 4 ticks, then IDLE with audio_run=0; l_data_out=0 after the last tick.
- Source switch: in RUN change mux_sel_req 0->2 -> ramp down, mux_sel becomes 2 only when gain==0, 2 muted ticks, ramp up to 256, status[4]=1 during the ramp down.
- Watchdog: in RUN stop src_valid for 200 clk -> gain=0 the same cycle, state LOCK, status[3]=1; status_clr clears it; 4 src_valid pulses -> RAMP_UP.
- Abort and negatives: enable_req re-asserted at gain=128 during ramp down -> RAMP_UP resumes from 128; input 0x800000 at gain 128 -> output 0xC00000; async reset asserted mid-RAMP_UP -> all outputs 0 immediately.
